// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential packed-BCD to binary converter.
// Consumes one BCD digit per clock, most significant digit first,
// accumulating acc = acc*10 + digit. A non-BCD nibble forces a zero result
// and raises err. All outputs are registered.
module bcd_to_bin_seq #(
    parameter int unsigned NDIG = 4,
    parameter int unsigned BW   = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic [BW-1:0]     bin_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t            state;
    logic [4*NDIG-1:0] sreg;
    logic [BW-1:0]     acc;
    logic [CW-1:0]     cnt;
    logic              errf;

    logic [3:0]        dig;
    logic              dig_bad;
    logic [BW-1:0]     acc_next;

    // Current digit step: top nibble of the shift register folded into acc.
    always_comb begin
        dig      = sreg[4*NDIG-1 -: 4];
        dig_bad  = (dig > 4'd9);
        acc_next = (acc << 3) + (acc << 1) + BW'(dig);
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sreg    <= '0;
            acc     <= '0;
            cnt     <= '0;
            errf    <= 1'b0;
            bin_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg  <= bcd_in;
                        acc   <= '0;
                        cnt   <= '0;
                        errf  <= 1'b0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    acc  <= acc_next;
                    sreg <= sreg << 4;
                    errf <= errf | dig_bad;
                    if (cnt == CW'(NDIG - 1)) begin
                        // Final digit: its own error bit must be included here.
                        bin_out <= (errf | dig_bad) ? '0 : acc_next;
                        err     <= errf | dig_bad;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
